// File: rtl/dff_pipe_sr.sv
// dff_pipe_sr: WIDTH-bit, DEPTH-stage retiming pipeline with load enable,
// per-stage valid tracking and a synchronous set override.
// Priority on every rising edge: reset, then set, then shift, then hold.
// All outputs come straight from registers, so there is no combinational
// path from any input to any output.

module dff_pipe_sr #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           DEPTH     = 2,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter logic [WIDTH-1:0]      SET_VAL   = '1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             setb,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy
);

    // Stage 0 is the input end; stage DEPTH-1 drives q.
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;

    // Pipeline state: reset beats set, set beats shift, otherwise hold.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled inside the clocked block, so it only acts on
        // an edge; non-blocking assignments let every stage read the value
        // its neighbour held before this edge, which is what makes the shift.
        if (!resetb) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data[i] <= RESET_VAL;
            end
            vld <= '0;
        end else if (!setb) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data[i] <= SET_VAL;
            end
            vld <= '1;
        end else if (en) begin
            data[0] <= d;
            vld[0]  <= d_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data[i] <= data[i-1];
                vld[i]  <= vld[i-1];
            end
        end
    end

    // Outputs are taken directly from the last stage and the valid register.
    always_comb begin
        q       = data[DEPTH-1];
        q_valid = vld[DEPTH-1];
        busy    = |vld;
    end

endmodule
